// File: rtl/shared_ram_pkg.sv
// Shared types for the unified instruction/data memory controller.
package shared_ram_pkg;

    localparam int unsigned WAIT_CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef enum logic {
        GNT_INSTR = 1'b0,
        GNT_DATA  = 1'b1
    } gnt_t;

    // Round-robin pick: a lone request wins outright, a tie goes opposite the last grant.
    function automatic gnt_t pick_grant(input logic ireq, input logic dreq, input gnt_t last);
        if (ireq && dreq) begin
            return (last == GNT_DATA) ? GNT_INSTR : GNT_DATA;
        end else if (ireq) begin
            return GNT_INSTR;
        end else begin
            return GNT_DATA;
        end
    endfunction

endpackage

// File: rtl/shared_ram_ctrl_if.sv
// Fetch and load/store port bundle of the shared memory.
interface shared_ram_ctrl_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 16
);
    localparam int unsigned BE_W = DATA_WIDTH / 8;

    logic                  ireq;
    logic [ADDR_WIDTH-1:0] iaddr;
    logic [DATA_WIDTH-1:0] idata;
    logic                  iack;
    logic                  dreq;
    logic                  dwrite;
    logic [ADDR_WIDTH-1:0] daddr;
    logic [DATA_WIDTH-1:0] dwdata;
    logic [BE_W-1:0]       dbyte_en;
    logic [DATA_WIDTH-1:0] drdata;
    logic                  dack;
    logic                  derr;
    logic                  busy;

    modport master (
        output ireq, iaddr, dreq, dwrite, daddr, dwdata, dbyte_en,
        input  idata, iack, drdata, dack, derr, busy
    );

    modport slave (
        input  ireq, iaddr, dreq, dwrite, daddr, dwdata, dbyte_en,
        output idata, iack, drdata, dack, derr, busy
    );

endinterface

// File: rtl/ram_array.sv
// Single-port word storage with byte-lane write enables; mem is left visible for preload/dump.
module ram_array #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 1024,
    parameter int unsigned IDX_W      = 10
) (
    input  logic                    clk,
    input  logic                    we,
    input  logic [IDX_W-1:0]        addr,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [DATA_WIDTH/8-1:0] be,
    output logic [DATA_WIDTH-1:0]   rdata_c
);
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Asynchronous read so the controller sees the old word at the commit edge.
    assign rdata_c = mem[addr];

    // Byte-masked write commit.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int k = 0; k < DATA_WIDTH / 8; k++) begin
                if (be[k]) begin
                    mem[addr][8*k +: 8] <= wdata[8*k +: 8];
                end
            end
        end
    end

endmodule

// File: rtl/shared_ram_ctrl.sv
// Unified instruction/data memory: round-robin arbitration of a fetch and a load/store port onto one array.
module shared_ram_ctrl
    import shared_ram_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned ADDR_WIDTH  = 16,
    parameter int unsigned DEPTH       = 1024,
    parameter int unsigned WAIT_STATES = 1
) (
    input logic               clk,
    input logic               rst,
    shared_ram_ctrl_if.slave  bus
);
    localparam int unsigned BE_W  = DATA_WIDTH / 8;
    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH + 1)'(DEPTH);

    state_t                state, state_next;
    logic [WAIT_CNT_W-1:0] wait_cnt, wait_cnt_next;
    gnt_t                  last_grant, last_grant_next;
    gnt_t                  gnt, gnt_next;
    gnt_t                  grant_c;
    logic [ADDR_WIDTH-1:0] addr, addr_next;
    logic                  write, write_next;
    logic [DATA_WIDTH-1:0] wdata, wdata_next;
    logic [BE_W-1:0]       be, be_next;

    logic [DATA_WIDTH-1:0] idata_r, idata_next;
    logic [DATA_WIDTH-1:0] drdata_r, drdata_next;
    logic                  iack_r, iack_next;
    logic                  dack_r, dack_next;
    logic                  derr_r, derr_next;
    logic                  busy_r, busy_next;

    logic                  in_range_c;
    logic                  we_c;
    logic [DATA_WIDTH-1:0] rd_word_c;
    logic [DATA_WIDTH-1:0] merged_c;

    assign grant_c    = pick_grant(bus.ireq, bus.dreq, last_grant);
    assign in_range_c = ({1'b0, addr} < DEPTH_L);
    assign we_c       = (state == RESP) && (gnt == GNT_DATA) && write && in_range_c && !rst;

    ram_array #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .IDX_W      (IDX_W)
    ) u_ram (
        .clk     (clk),
        .we      (we_c),
        .addr    (addr[IDX_W-1:0]),
        .wdata   (wdata),
        .be      (be),
        .rdata_c (rd_word_c)
    );

    // Post-write word returned on a data write ack.
    always_comb begin
        merged_c = rd_word_c;
        for (int k = 0; k < int'(BE_W); k++) begin
            if (be[k]) begin
                merged_c[8*k +: 8] = wdata[8*k +: 8];
            end
        end
    end

    // State, latched request and registered port outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            wait_cnt   <= '0;
            last_grant <= GNT_DATA;
            gnt        <= GNT_INSTR;
            addr       <= '0;
            write      <= 1'b0;
            wdata      <= '0;
            be         <= '0;
            idata_r    <= '0;
            drdata_r   <= '0;
            iack_r     <= 1'b0;
            dack_r     <= 1'b0;
            derr_r     <= 1'b0;
            busy_r     <= 1'b0;
        end else begin
            state      <= state_next;
            wait_cnt   <= wait_cnt_next;
            last_grant <= last_grant_next;
            gnt        <= gnt_next;
            addr       <= addr_next;
            write      <= write_next;
            wdata      <= wdata_next;
            be         <= be_next;
            idata_r    <= idata_next;
            drdata_r   <= drdata_next;
            iack_r     <= iack_next;
            dack_r     <= dack_next;
            derr_r     <= derr_next;
            busy_r     <= busy_next;
        end
    end

    // Next-state: grant in IDLE, count wait states, complete the access in RESP.
    always_comb begin
        state_next      = state;
        wait_cnt_next   = wait_cnt;
        last_grant_next = last_grant;
        gnt_next        = gnt;
        addr_next       = addr;
        write_next      = write;
        wdata_next      = wdata;
        be_next         = be;
        idata_next      = idata_r;
        drdata_next     = drdata_r;
        iack_next       = 1'b0;
        dack_next       = 1'b0;
        derr_next       = 1'b0;

        case (state)
            IDLE: begin
                if (bus.ireq || bus.dreq) begin
                    gnt_next        = grant_c;
                    last_grant_next = grant_c;
                    wait_cnt_next   = '0;
                    if (grant_c == GNT_INSTR) begin
                        addr_next  = bus.iaddr;
                        write_next = 1'b0;
                    end else begin
                        addr_next  = bus.daddr;
                        write_next = bus.dwrite;
                        wdata_next = bus.dwdata;
                        be_next    = bus.dbyte_en;
                    end
                    state_next = (WAIT_STATES > 0) ? WAIT : RESP;
                end
            end
            WAIT: begin
                if (wait_cnt == WAIT_CNT_W'(WAIT_STATES - 1)) begin
                    state_next = RESP;
                end else begin
                    wait_cnt_next = wait_cnt + WAIT_CNT_W'(1);
                end
            end
            RESP: begin
                state_next = IDLE;
                if (gnt == GNT_INSTR) begin
                    iack_next  = 1'b1;
                    idata_next = in_range_c ? rd_word_c : '0;
                end else begin
                    dack_next   = 1'b1;
                    derr_next   = !in_range_c;
                    drdata_next = !in_range_c ? '0 : (write ? merged_c : rd_word_c);
                end
            end
            default: state_next = IDLE;
        endcase

        busy_next = (state_next != IDLE);
    end

    assign bus.idata  = idata_r;
    assign bus.iack   = iack_r;
    assign bus.drdata = drdata_r;
    assign bus.dack   = dack_r;
    assign bus.derr   = derr_r;
    assign bus.busy   = busy_r;

endmodule

// File: tb/tb_shared_ram_ctrl.sv
// Scoreboard bench for shared_ram_ctrl (32-bit words, 1024 deep, one wait state).
module tb_shared_ram_ctrl;

    localparam int unsigned WS  = 1;
    localparam int          LAT = WS + 2;

    typedef struct packed {
        logic        port;
        logic [31:0] data;
        logic        err;
    } exp_t;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_fail;
    exp_t sb[$];

    shared_ram_ctrl_if #(.DATA_WIDTH(32), .ADDR_WIDTH(16)) bus ();

    shared_ram_ctrl #(
        .DATA_WIDTH  (32),
        .ADDR_WIDTH  (16),
        .DEPTH       (1024),
        .WAIT_STATES (WS)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] pattern(input int i);
        return (32'(i) * 32'h9E37_79B1) ^ 32'h5A5A_0000;
    endfunction

    // Drive one request on a port and wait (bounded) for its ack.
    task automatic txn(input logic is_data, input logic wr, input logic [15:0] a,
                       input logic [31:0] wd, input logic [3:0] be,
                       output logic [31:0] rd, output logic err, output int lat,
                       output logic tmo, output logic other);
        @(negedge clk);
        if (is_data) begin
            bus.dreq = 1'b1; bus.dwrite = wr; bus.daddr = a; bus.dwdata = wd; bus.dbyte_en = be;
        end else begin
            bus.ireq = 1'b1; bus.iaddr = a;
        end
        lat = 0; tmo = 1'b1; other = 1'b0; rd = '0; err = 1'b0;
        for (int i = 0; i < 40 && tmo; i++) begin
            @(negedge clk);
            lat++;
            if (is_data ? bus.iack : bus.dack) other = 1'b1;
            if (is_data ? bus.dack : bus.iack) begin
                tmo = 1'b0;
                rd  = is_data ? bus.drdata : bus.idata;
                err = bus.derr;
            end
        end
        bus.ireq = 1'b0;
        bus.dreq = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        n_cmp++;
        if ({bus.idata, bus.iack, bus.drdata, bus.dack, bus.derr, bus.busy} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: idata=%h iack=%b drdata=%h dack=%b derr=%b busy=%b, want all 0",
                     bus.idata, bus.iack, bus.drdata, bus.dack, bus.derr, bus.busy);
        end
        rst = 1'b0;
    endtask

    task automatic test_fetch;
        logic [31:0] rd; logic err, tmo, other; int lat; exp_t e;
        dut.u_ram.mem[1] = 32'h0000_0D51;
        sb.push_back(exp_t'{port: 1'b0, data: 32'h0000_0D51, err: 1'b0});
        txn(1'b0, 1'b0, 16'd1, '0, '0, rd, err, lat, tmo, other);
        e = sb.pop_front();
        n_cmp++;
        if (tmo !== 1'b0 || lat != LAT) begin
            n_fail++; $display("FAIL fetch_latency: got %0d (timeout=%b), want %0d", lat, tmo, LAT);
        end
        n_cmp++;
        if (rd !== e.data) begin
            n_fail++; $display("FAIL fetch_data: got %h, want %h", rd, e.data);
        end
        n_cmp++;
        if (other !== 1'b0) begin
            n_fail++; $display("FAIL fetch_no_dack: dack seen=%b, want 0", other);
        end
        @(negedge clk);
        n_cmp++;
        if (bus.iack !== 1'b0 || bus.idata !== e.data) begin
            n_fail++; $display("FAIL fetch_hold: iack=%b idata=%h, want 0 / %h", bus.iack, bus.idata, e.data);
        end
    endtask

    task automatic test_write_read;
        logic [31:0] rd; logic err, tmo, other; int lat; exp_t e;
        sb.push_back(exp_t'{port: 1'b1, data: 32'd3409, err: 1'b0});
        txn(1'b1, 1'b1, 16'd17, 32'd3409, 4'b1111, rd, err, lat, tmo, other);
        e = sb.pop_front();
        n_cmp++;
        if (tmo !== 1'b0 || lat != LAT || rd !== e.data || err !== e.err) begin
            n_fail++; $display("FAIL write17_ack: lat=%0d tmo=%b drdata=%h derr=%b, want %0d 0 %h %b",
                               lat, tmo, rd, err, LAT, e.data, e.err);
        end
        sb.push_back(exp_t'{port: 1'b1, data: 32'd3409, err: 1'b0});
        txn(1'b1, 1'b0, 16'd17, 32'hFFFF_FFFF, 4'b1111, rd, err, lat, tmo, other);
        e = sb.pop_front();
        n_cmp++;
        if (tmo !== 1'b0 || rd !== e.data) begin
            n_fail++; $display("FAIL read17_data: got %h (tmo=%b), want %h", rd, tmo, e.data);
        end
        n_cmp++;
        if (err !== e.err) begin
            n_fail++; $display("FAIL read17_derr: got %b, want %b", err, e.err);
        end
        sb.push_back(exp_t'{port: 1'b0, data: 32'd3409, err: 1'b0});
        txn(1'b0, 1'b0, 16'd17, '0, '0, rd, err, lat, tmo, other);
        e = sb.pop_front();
        n_cmp++;
        if (tmo !== 1'b0 || rd !== e.data || other !== 1'b0) begin
            n_fail++; $display("FAIL fetch17: idata=%h tmo=%b dack_seen=%b, want %h 0 0", rd, tmo, other, e.data);
        end
        n_cmp++;
        if (bus.drdata !== 32'd3409) begin
            n_fail++; $display("FAIL drdata_held: got %h, want %h", bus.drdata, 32'd3409);
        end
    endtask

    task automatic test_byte_enable;
        logic [31:0] rd; logic err, tmo, other; int lat; exp_t e;
        dut.u_ram.mem[33] = 32'h1122_3344;
        sb.push_back(exp_t'{port: 1'b1, data: 32'h11BB_33DD, err: 1'b0});
        txn(1'b1, 1'b1, 16'd33, 32'hAABB_CCDD, 4'b0101, rd, err, lat, tmo, other);
        e = sb.pop_front();
        n_cmp++;
        if (tmo !== 1'b0 || rd !== e.data) begin
            n_fail++; $display("FAIL be_write_ack: got %h (tmo=%b), want %h", rd, tmo, e.data);
        end
        sb.push_back(exp_t'{port: 1'b1, data: 32'h11BB_33DD, err: 1'b0});
        txn(1'b1, 1'b0, 16'd33, '0, 4'b0000, rd, err, lat, tmo, other);
        e = sb.pop_front();
        n_cmp++;
        if (tmo !== 1'b0 || rd !== e.data || err !== e.err) begin
            n_fail++; $display("FAIL be_read: got %h derr=%b (tmo=%b), want %h %b", rd, err, tmo, e.data, e.err);
        end
    endtask

    task automatic test_back_to_back;
        exp_t e; int last_ack; int n_ack; logic [31:0] got;
        @(negedge clk);
        rst = 1'b1;
        bus.ireq = 1'b1; bus.iaddr = 16'd1;
        bus.dreq = 1'b1; bus.dwrite = 1'b0; bus.daddr = 16'd17;
        sb.push_back(exp_t'{port: 1'b0, data: 32'h0000_0D51, err: 1'b0});
        sb.push_back(exp_t'{port: 1'b1, data: 32'd3409,      err: 1'b0});
        sb.push_back(exp_t'{port: 1'b0, data: 32'h0000_0D51, err: 1'b0});
        sb.push_back(exp_t'{port: 1'b1, data: 32'd3409,      err: 1'b0});
        @(negedge clk);
        rst = 1'b0;
        last_ack = -1; n_ack = 0;
        for (int cyc = 0; cyc < 40 && n_ack < 4; cyc++) begin
            @(negedge clk);
            if (bus.iack && bus.dack) begin
                n_cmp++; n_fail++;
                $display("FAIL b2b_both_acks: iack=1 dack=1 at cycle %0d, want one", cyc);
            end else if (bus.iack || bus.dack) begin
                if (sb.size() == 0) begin
                    n_cmp++; n_fail++;
                    $display("FAIL b2b_extra_ack: ack at cycle %0d, want none", cyc);
                end else begin
                    e = sb.pop_front();
                    got = bus.dack ? bus.drdata : bus.idata;
                    n_cmp++;
                    if (bus.dack !== e.port || got !== e.data) begin
                        n_fail++; $display("FAIL b2b_order: port=%b data=%h, want port=%b data=%h",
                                           bus.dack, got, e.port, e.data);
                    end
                    n_cmp++;
                    if ((last_ack < 0 && cyc != LAT - 1) || (last_ack >= 0 && cyc - last_ack != LAT)) begin
                        n_fail++; $display("FAIL b2b_spacing: ack at cycle %0d, previous %0d, want gap %0d",
                                           cyc, last_ack, LAT);
                    end
                    last_ack = cyc;
                    n_ack++;
                end
            end
        end
        bus.ireq = 1'b0;
        bus.dreq = 1'b0;
        n_cmp++;
        if (sb.size() != 0) begin
            n_fail++; $display("FAIL b2b_pending: %0d acks missing, want 0", sb.size());
        end
        sb.delete();
    endtask

    task automatic test_out_of_range;
        logic [31:0] rd; logic err, tmo, other; int lat; exp_t e; int bad;
        for (int i = 0; i < 1024; i++) dut.u_ram.mem[i] = pattern(i);
        sb.push_back(exp_t'{port: 1'b1, data: 32'h0, err: 1'b1});
        txn(1'b1, 1'b0, 16'd1024, '0, '0, rd, err, lat, tmo, other);
        e = sb.pop_front();
        n_cmp++;
        if (tmo !== 1'b0 || rd !== e.data || err !== e.err) begin
            n_fail++; $display("FAIL oor_read: drdata=%h derr=%b tmo=%b, want %h %b", rd, err, tmo, e.data, e.err);
        end
        txn(1'b1, 1'b1, 16'd1024, 32'hFFFF_FFFF, 4'b1111, rd, err, lat, tmo, other);
        n_cmp++;
        if (tmo !== 1'b0 || err !== 1'b1) begin
            n_fail++; $display("FAIL oor_write_derr: derr=%b tmo=%b, want 1", err, tmo);
        end
        bad = 0;
        for (int i = 0; i < 1024; i++) if (dut.u_ram.mem[i] !== pattern(i)) bad++;
        n_cmp++;
        if (bad != 0) begin
            n_fail++; $display("FAIL oor_write_dropped: %0d words changed, want 0", bad);
        end
        sb.push_back(exp_t'{port: 1'b0, data: 32'h0, err: 1'b0});
        txn(1'b0, 1'b0, 16'd1024, '0, '0, rd, err, lat, tmo, other);
        e = sb.pop_front();
        n_cmp++;
        if (tmo !== 1'b0 || rd !== e.data || err !== e.err || other !== 1'b0) begin
            n_fail++; $display("FAIL oor_fetch: idata=%h derr=%b tmo=%b dack_seen=%b, want 0 0 0 0",
                               rd, err, tmo, other);
        end
        sb.push_back(exp_t'{port: 1'b1, data: pattern(1023), err: 1'b0});
        txn(1'b1, 1'b0, 16'd1023, '0, '0, rd, err, lat, tmo, other);
        e = sb.pop_front();
        n_cmp++;
        if (tmo !== 1'b0 || rd !== e.data || err !== e.err) begin
            n_fail++; $display("FAIL last_word_read: drdata=%h derr=%b tmo=%b, want %h %b", rd, err, tmo, e.data, e.err);
        end
    endtask

    task automatic test_reset_abort;
        logic [31:0] rd; logic err, tmo, other; int lat; exp_t e; logic saw_ack;
        @(negedge clk);
        bus.dreq = 1'b1; bus.dwrite = 1'b1; bus.daddr = 16'd5;
        bus.dwdata = 32'hDEAD_BEEF; bus.dbyte_en = 4'b1111;
        @(negedge clk);
        n_cmp++;
        if (bus.busy !== 1'b1) begin
            n_fail++; $display("FAIL abort_busy_before: got %b, want 1", bus.busy);
        end
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({bus.idata, bus.iack, bus.drdata, bus.dack, bus.derr, bus.busy} !== '0) begin
            n_fail++; $display("FAIL abort_outputs: idata=%h iack=%b drdata=%h dack=%b derr=%b busy=%b, want all 0",
                               bus.idata, bus.iack, bus.drdata, bus.dack, bus.derr, bus.busy);
        end
        bus.dreq = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        saw_ack = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (bus.dack || bus.busy) saw_ack = 1'b1;
        end
        n_cmp++;
        if (saw_ack !== 1'b0) begin
            n_fail++; $display("FAIL abort_no_ack: dack/busy seen=%b, want 0", saw_ack);
        end
        sb.push_back(exp_t'{port: 1'b1, data: pattern(5), err: 1'b0});
        txn(1'b1, 1'b0, 16'd5, '0, '0, rd, err, lat, tmo, other);
        e = sb.pop_front();
        n_cmp++;
        if (tmo !== 1'b0 || rd !== e.data) begin
            n_fail++; $display("FAIL abort_old_contents: got %h (tmo=%b), want %h", rd, tmo, e.data);
        end
    endtask

    initial begin
        n_cmp = 0; n_fail = 0;
        rst = 1'b1;
        bus.ireq = 1'b0; bus.iaddr = '0;
        bus.dreq = 1'b0; bus.dwrite = 1'b0; bus.daddr = '0;
        bus.dwdata = '0; bus.dbyte_en = '0;
        test_reset();
        test_fetch();
        test_write_read();
        test_byte_enable();
        test_back_to_back();
        test_out_of_range();
        test_reset_abort();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
